// File: rtl/synth_pkg.sv
// Shared types and widths for the envelope generator.
package synth_pkg;

    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned ENV_W    = 8;

    typedef enum logic [2:0] {
        StIdle,
        StAttack,
        StDecay,
        StSustain,
        StRelease
    } env_state_t;

    // Approximately exponential release step: level/8, never less than 1 so the
    // envelope always reaches zero.
    function automatic logic [ENV_W-1:0] exp_release_step(input logic [ENV_W-1:0] level);
        logic [ENV_W-1:0] shifted;
        shifted = level >> 3;
        return (shifted == '0) ? ENV_W'(1) : shifted;
    endfunction

endpackage

// File: rtl/env_tick_div.sv
// Free-running divider producing a one-cycle tick every DIV clock cycles.
module env_tick_div #(
    parameter int unsigned DIV = 12000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Strobe on the last count, then wrap to zero.
    always_comb begin
        tick  = (cnt_q == CntMax);
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/envelope_gen.sv
// ADSR-style envelope generator: gate-driven attack/decay/sustain/release state
// machine stepping the level once per divided tick, and a registered multiply of
// the incoming wave sample by the level.
// Build option: define ENV_EXP_RELEASE_EN for a level/8 (approximately
// exponential) release instead of the linear REL_RATE release.
module envelope_gen
    import synth_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 12000,
    parameter int unsigned ATK_RATE  = 16,
    parameter int unsigned DEC_RATE  = 4,
    parameter int unsigned SUS_LEVEL = 160,
    parameter int unsigned REL_RATE  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                gate,
    input  logic [SAMPLE_W-1:0] wave_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic [ENV_W-1:0]    env_level,
    output logic                active
);

    localparam int unsigned ProdW = SAMPLE_W + ENV_W;

    localparam logic [ENV_W-1:0] AtkRate  = ENV_W'(ATK_RATE);
    localparam logic [ENV_W-1:0] DecRate  = ENV_W'(DEC_RATE);
    localparam logic [ENV_W-1:0] SusLevel = ENV_W'(SUS_LEVEL);
    localparam logic [ENV_W-1:0] LevelMax = '1;
    // Decay lands on SUS_LEVEL once one more step would reach or pass it.
    localparam logic [ENV_W:0]   DecLimit = (ENV_W + 1)'(SUS_LEVEL + DEC_RATE);

    env_state_t          state_q, state_d;
    logic [ENV_W-1:0]    level_q, level_d;
    logic                gate_q;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                active_q;

    logic                tick;
    logic                gate_rise;
    logic                gate_fall;
    logic [ENV_W:0]      atk_sum;
    logic [ENV_W-1:0]    rel_dec;
    logic [ProdW-1:0]    prod;

    env_tick_div #(
        .DIV (TICK_DIV)
    ) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Gate events; gate low only matters while the key is still being voiced.
    always_comb begin
        gate_rise = gate & ~gate_q;
        gate_fall = ~gate & ((state_q == StAttack) || (state_q == StDecay) ||
                             (state_q == StSustain));
    end

    // Release decrement selected at build time.
    always_comb begin
`ifdef ENV_EXP_RELEASE_EN
        rel_dec = exp_release_step(level_q);
`else
        rel_dec = ENV_W'(REL_RATE);
`endif
    end

    // Next state and level; gate events take priority and freeze the level.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        atk_sum = {1'b0, level_q} + {1'b0, AtkRate};

        if (gate_rise) begin
            // Retrigger keeps the current level to avoid a click.
            state_d = StAttack;
        end else if (gate_fall) begin
            state_d = StRelease;
        end else begin
            unique case (state_q)
                StIdle: begin
                    level_d = '0;
                end
                StAttack: begin
                    if (tick) begin
                        if (atk_sum >= {1'b0, LevelMax}) begin
                            level_d = LevelMax;
                            state_d = StDecay;
                        end else begin
                            level_d = atk_sum[ENV_W-1:0];
                        end
                    end
                end
                StDecay: begin
                    if (tick) begin
                        if ({1'b0, level_q} <= DecLimit) begin
                            level_d = SusLevel;
                            state_d = StSustain;
                        end else begin
                            level_d = level_q - DecRate;
                        end
                    end
                end
                StSustain: begin
                    level_d = SusLevel;
                end
                StRelease: begin
                    if (tick) begin
                        if (level_q <= rel_dec) begin
                            level_d = '0;
                            state_d = StIdle;
                        end else begin
                            level_d = level_q - rel_dec;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    level_d = '0;
                end
            endcase
        end
    end

    // Scaled sample: top byte of wave * level, forced silent when idle.
    always_comb begin
        prod     = ProdW'(wave_in) * ProdW'(level_q);
        sample_d = (state_q == StIdle) ? '0 : prod[ProdW-1 -: SAMPLE_W];
    end

    // State, level, gate history and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            level_q  <= '0;
            gate_q   <= 1'b0;
            sample_q <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            gate_q   <= gate;
            sample_q <= sample_d;
            active_q <= (state_d != StIdle);
        end
    end

    assign sample_out = sample_q;
    assign env_level  = level_q;
    assign active     = active_q;

endmodule

// File: tb/tb_envelope_gen.sv
// Directed bench for envelope_gen with TICK_DIV=4 and default rates.
module tb_envelope_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       gate;
    logic [7:0] wave_in;
    logic [7:0] sample_out;
    logic [7:0] env_level;
    logic       active;

    int tests = 0;
    int fails = 0;

    envelope_gen #(
        .TICK_DIV  (4),
        .ATK_RATE  (16),
        .DEC_RATE  (4),
        .SUS_LEVEL (160),
        .REL_RATE  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gate       (gate),
        .wave_in    (wave_in),
        .sample_out (sample_out),
        .env_level  (env_level),
        .active     (active)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_change(input logic [7:0] prev, output logic [7:0] val,
                               output int cyc, output bit ok);
        ok  = 1'b0;
        val = prev;
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (env_level !== prev) begin
                val = env_level;
                cyc = i;
                ok  = 1'b1;
                return;
            end
        end
    endtask

    // Expected level after one tick: 0 attack, 1 decay, 2 release.
    function automatic logic [7:0] model_step(input int ph, input logic [7:0] l);
        int d;
        case (ph)
            0: return (int'(l) + 16 >= 255) ? 8'd255 : 8'(int'(l) + 16);
            1: return (int'(l) - 4 <= 160) ? 8'd160 : 8'(int'(l) - 4);
            default: begin
`ifdef ENV_EXP_RELEASE_EN
                d = ((int'(l) >> 3) < 1) ? 1 : (int'(l) >> 3);
`else
                d = 2;
`endif
                return (int'(l) <= d) ? 8'd0 : 8'(int'(l) - d);
            end
        endcase
    endfunction

    function automatic bit phase_done(input int ph, input logic [7:0] l, input logic [7:0] stop);
        case (ph)
            0:       return l == 8'd255;
            1:       return l == 8'd160;
            default: return l <= stop;
        endcase
    endfunction

    // Follow one phase tick by tick, checking every level and the tick spacing.
    task automatic run_phase(input int ph, input logic [7:0] start, input logic [7:0] stop,
                             output logic [7:0] fin, output int steps);
        logic [7:0] lvl, val, exp;
        int         cyc, bad;
        bit         ok;
        string      tag;
        tag   = (ph == 0) ? "attack_level" : (ph == 1) ? "decay_level" : "release_level";
        lvl   = start;
        steps = 0;
        bad   = 0;
        while (!phase_done(ph, lvl, stop) && steps < 300) begin
            wait_change(lvl, val, cyc, ok);
            if (!ok) begin
                chk({tag, "_timeout"}, 32'(ok), 32'd1);
                break;
            end
            exp = model_step(ph, lvl);
            chk(tag, val, exp);
            if (steps > 0 && cyc != 4) bad++;
            steps++;
            lvl = val;
        end
        chk({tag, "_spacing"}, bad, 0);
        fin = lvl;
    endtask

    initial begin
        logic [7:0] lvl, val;
        int         steps, cyc, bad;
        bit         ok;

        // Reset with gate low.
        reset   = 1'b1;
        gate    = 1'b0;
        wave_in = 8'd255;
        repeat (3) step();
        chk("rst_sample", sample_out, 0);
        chk("rst_level", env_level, 0);
        chk("rst_active", active, 0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (active !== 1'b0 || env_level !== 8'd0 || sample_out !== 8'd0) bad++;
        end
        chk("idle_quiet_100", bad, 0);

        // Full attack and decay with gate held.
        gate = 1'b1;
        step();
        chk("gate_rise_active", active, 1);
        run_phase(0, 8'd0, 8'd0, lvl, steps);
        chk("attack_ticks", steps, 16);
        run_phase(1, lvl, 8'd0, lvl, steps);
        chk("decay_ticks", steps, 24);
        chk("sample_before_sus", sample_out, 162);  // 255*163 >> 8
        step();
        chk("sample_at_sus", sample_out, 159);      // 255*160 >> 8
        repeat (20) step();
        chk("sustain_hold", env_level, 160);
        wave_in = 8'd100;
        step();
        chk("sample_wave100", sample_out, 62);      // 100*160 >> 8
        wave_in = 8'd255;

        // Full release to idle.
        gate = 1'b0;
        step();
        chk("release_entry_level", env_level, 160);
        chk("release_entry_active", active, 1);
        run_phase(2, 8'd160, 8'd0, lvl, steps);
`ifndef ENV_EXP_RELEASE_EN
        chk("release_ticks", steps, 80);
`endif
        chk("idle_after_release", active, 0);
        step();
        chk("idle_sample", sample_out, 0);
        repeat (10) step();
        chk("idle_level", env_level, 0);

        // Retrigger during release.
        gate = 1'b1;
        run_phase(0, 8'd0, 8'd0, lvl, steps);
        run_phase(1, lvl, 8'd0, lvl, steps);
        gate = 1'b0;
        run_phase(2, 8'd160, 8'd100, lvl, steps);
        gate = 1'b1;
        wait_change(lvl, val, cyc, ok);
        chk("retrig_change_seen", 32'(ok), 1);
        chk("retrig_level", val, model_step(0, lvl));
        chk("retrig_active", active, 1);

        // Gate rise on the same cycle as a release tick.
        run_phase(0, val, 8'd0, lvl, steps);
        run_phase(1, lvl, 8'd0, lvl, steps);
        gate = 1'b0;
        run_phase(2, 8'd160, 8'd50, lvl, steps);
        chk("coinc_level_50", lvl, 50);
        repeat (3) step();
        chk("coinc_pre", env_level, lvl);
        gate = 1'b1;
        step();
        chk("coinc_hold", env_level, lvl);
        chk("coinc_active", active, 1);
        wait_change(lvl, val, cyc, ok);
        chk("coinc_attack", val, model_step(0, lvl));

        // Asynchronous reset mid-envelope, released with gate still high.
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_level", env_level, 0);
        chk("midrst_active", active, 0);
        chk("midrst_sample", sample_out, 0);
        repeat (2) step();
        reset = 1'b0;
        step();
        chk("post_rst_rise", active, 1);
        repeat (2) step();
        chk("post_rst_pre_tick", env_level, 0);
        step();
        chk("post_rst_first_tick", env_level, 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
